// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types, default geometry and address slicing for the data cache
//
// Contents:
//   DEF_INDEX_W / DEF_OFFSET_W / DEF_TAG_W : default cache geometry (256 lines x 4 words)
//   state_t + S_* constants                : controller sequencing states
//   addr_tag / addr_index / addr_offset    : field extraction for the default geometry

package dcache_pkg;

    localparam int DEF_INDEX_W  = 8;
    localparam int DEF_OFFSET_W = 2;
    localparam int DEF_TAG_W    = 32 - DEF_INDEX_W - DEF_OFFSET_W - 2;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_WB   = 2'd1;
    localparam state_t S_FILL = 2'd2;
    localparam state_t S_DONE = 2'd3;

    function automatic logic [DEF_TAG_W-1:0] addr_tag(input logic [31:0] a);
        return a[31 -: DEF_TAG_W];
    endfunction

    function automatic logic [DEF_INDEX_W-1:0] addr_index(input logic [31:0] a);
        return a[DEF_OFFSET_W+2 +: DEF_INDEX_W];
    endfunction

    function automatic logic [DEF_OFFSET_W-1:0] addr_offset(input logic [31:0] a);
        return a[2 +: DEF_OFFSET_W];
    endfunction

endpackage

// File: rtl/dcache_controller_if.sv
// rtl/dcache_controller_if.sv - core-side and backing-memory-side signals of the data cache
//
// Core side : addr, data_in, write_enable, read_enable -> cache; data_out, ready, miss <- cache
// Mem side  : mem_req, mem_we, mem_addr, mem_wdata <- cache; mem_ack, mem_rdata -> cache
// Modports  : slave  = the cache controller
//             master = the environment (MEM stage plus DRAM/AXI bridge)

interface dcache_controller_if;

    logic [31:0] addr;
    logic [31:0] data_in;
    logic        write_enable;
    logic        read_enable;
    logic [31:0] data_out;
    logic        ready;
    logic        miss;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  addr, data_in, write_enable, read_enable, mem_ack, mem_rdata,
        output data_out, ready, miss, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output addr, data_in, write_enable, read_enable, mem_ack, mem_rdata,
        input  data_out, ready, miss, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dcache_data_ram.sv
// rtl/dcache_data_ram.sv - 32-bit data array with one write port and one synchronous read port
//
// Ports:
//   clk      in   clock
//   we_i     in   write strobe
//   waddr_i  in   write word address
//   wdata_i  in   write data
//   raddr_i  in   read word address, sampled every cycle
//   rdata_o  out  read data, one cycle after raddr_i
// A read of the word being written in the same cycle returns the old contents.

module dcache_data_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [1<<AW];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-back write-allocate data cache controller
//
// Ports:
//   clk   in   clock
//   rstn  in   synchronous active-low reset; invalidates every line in one cycle
//   bus   slave modport of dcache_controller_if:
//         addr/data_in/write_enable/read_enable  request from the MEM stage
//         data_out/ready/miss                    response and stall to the MEM stage
//         mem_req/mem_we/mem_addr/mem_wdata      word-serial request to backing memory
//         mem_ack/mem_rdata                      word completion and fill data
// Requests are accepted in cycle T (ready=1) and resolve in T+1. A miss runs
// S_WB (dirty victim only) -> S_FILL -> S_DONE and resolves the cycle after S_DONE.

module dcache_controller
    import dcache_pkg::*;
#(
    parameter int INDEX_W  = DEF_INDEX_W,
    parameter int OFFSET_W = DEF_OFFSET_W
) (
    input  logic                clk,
    input  logic                rstn,
    dcache_controller_if.slave  bus
);

    localparam int TAG_W  = 32 - INDEX_W - OFFSET_W - 2;
    localparam int LINES  = 1 << INDEX_W;
    localparam int RAM_AW = INDEX_W + OFFSET_W;
    localparam logic [OFFSET_W-1:0] OFF_LAST = '1;

    // Fields of the address currently presented by the core
    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_idx;
    logic [OFFSET_W-1:0] req_off;
    logic                unused_addr_lsbs;

    assign req_tag          = bus.addr[31 -: TAG_W];
    assign req_idx          = bus.addr[OFFSET_W+2 +: INDEX_W];
    assign req_off          = bus.addr[2 +: OFFSET_W];
    assign unused_addr_lsbs = ^bus.addr[1:0];

    // Sequencing state and the latched request
    state_t              state_q,  state_d;
    logic                pend_q,   pend_d;
    logic                fin_q,    fin_d;
    logic                op_we_q,  op_we_d;
    logic [TAG_W-1:0]    tag_q,    tag_d;
    logic [INDEX_W-1:0]  idx_q,    idx_d;
    logic [OFFSET_W-1:0] woff_q,   woff_d;
    logic [31:0]         wdata_q,  wdata_d;
    logic [OFFSET_W-1:0] off_q,    off_d;

    // One-cycle bypass of the word written by a store hit
    logic                fwd_valid_q, fwd_valid_d;
    logic [RAM_AW-1:0]   fwd_addr_q,  fwd_addr_d;
    logic [31:0]         fwd_data_q,  fwd_data_d;

    logic [31:0]         data_out_q,  data_out_d;

    // Line state: valid/dirty in flops so reset clears them at once
    logic [LINES-1:0]    valid_q;
    logic [LINES-1:0]    dirty_q;
    logic [TAG_W-1:0]    tag_mem [LINES];
    logic [TAG_W-1:0]    tag_rd_q;

    logic                ram_we;
    logic [RAM_AW-1:0]   ram_waddr;
    logic [RAM_AW-1:0]   ram_raddr;
    logic [31:0]         ram_wdata;
    logic [31:0]         ram_rdata;

    logic                hit;
    logic                victim_dirty;
    logic                fwd_hit;
    logic                accept;
    logic                fill_done;
    logic                dirty_set;
    logic                miss_d;
    logic [OFFSET_W-1:0] off_inc;

    // tag_rd_q holds the tag read at accept; it stays put through the whole
    // miss and supplies the victim tag for the write-back addresses.
    assign hit          = valid_q[idx_q] && (tag_rd_q == tag_q);
    assign victim_dirty = valid_q[idx_q] && dirty_q[idx_q];
    assign fwd_hit      = fwd_valid_q && (fwd_addr_q == {idx_q, woff_q});
    assign off_inc      = off_q + 1'b1;

    assign bus.ready = rstn && (state_q == S_IDLE) && !(pend_q && !hit);
    assign accept    = bus.ready && (bus.read_enable || bus.write_enable);

    always_comb begin
        state_d     = state_q;
        pend_d      = 1'b0;
        fin_d       = 1'b0;
        op_we_d     = op_we_q;
        tag_d       = tag_q;
        idx_d       = idx_q;
        woff_d      = woff_q;
        wdata_d     = wdata_q;
        off_d       = off_q;
        fwd_valid_d = 1'b0;
        fwd_addr_d  = fwd_addr_q;
        fwd_data_d  = fwd_data_q;
        data_out_d  = data_out_q;
        ram_we      = 1'b0;
        ram_waddr   = {idx_q, woff_q};
        ram_wdata   = wdata_q;
        ram_raddr   = {req_idx, req_off};
        fill_done   = 1'b0;
        dirty_set   = 1'b0;
        miss_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    if (hit) begin
                        if (op_we_q) begin
                            ram_we      = 1'b1;
                            dirty_set   = 1'b1;
                            fwd_valid_d = 1'b1;
                            fwd_addr_d  = {idx_q, woff_q};
                            fwd_data_d  = wdata_q;
                        end else begin
                            data_out_d = fwd_hit ? fwd_data_q : ram_rdata;
                        end
                    end else begin
                        // Start reading victim word 0 now so it is on
                        // mem_wdata in the first write-back cycle.
                        miss_d    = 1'b1;
                        off_d     = '0;
                        ram_raddr = {idx_q, {OFFSET_W{1'b0}}};
                        state_d   = victim_dirty ? S_WB : S_FILL;
                    end
                end
                if (fin_q && !op_we_q) begin
                    data_out_d = ram_rdata;
                end
                if (accept) begin
                    pend_d  = 1'b1;
                    op_we_d = bus.write_enable;
                    tag_d   = req_tag;
                    idx_d   = req_idx;
                    woff_d  = req_off;
                    wdata_d = bus.data_in;
                end
            end

            S_WB: begin
                // Re-read the current word until it is acked so mem_wdata
                // stays stable, then move the read on to the next word.
                miss_d    = 1'b1;
                ram_raddr = {idx_q, off_q};
                if (bus.mem_ack) begin
                    off_d     = off_inc;
                    ram_raddr = {idx_q, off_inc};
                    if (off_q == OFF_LAST) begin
                        state_d = S_FILL;
                    end
                end
            end

            S_FILL: begin
                miss_d    = 1'b1;
                ram_waddr = {idx_q, off_q};
                ram_wdata = bus.mem_rdata;
                if (bus.mem_ack) begin
                    ram_we = 1'b1;
                    off_d  = off_inc;
                    if (off_q == OFF_LAST) begin
                        fill_done = 1'b1;
                        state_d   = S_DONE;
                    end
                end
            end

            S_DONE: begin
                // Store data merges into the freshly filled line here; the
                // read of the requested word is ready the following cycle.
                miss_d    = 1'b1;
                ram_raddr = {idx_q, woff_q};
                if (op_we_q) begin
                    ram_we    = 1'b1;
                    dirty_set = 1'b1;
                end
                fin_d   = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (!rstn) begin
            ram_we    = 1'b0;
            fill_done = 1'b0;
            dirty_set = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            pend_q      <= 1'b0;
            fin_q       <= 1'b0;
            op_we_q     <= 1'b0;
            tag_q       <= '0;
            idx_q       <= '0;
            woff_q      <= '0;
            wdata_q     <= '0;
            off_q       <= '0;
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
            data_out_q  <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            fin_q       <= fin_d;
            op_we_q     <= op_we_d;
            tag_q       <= tag_d;
            idx_q       <= idx_d;
            woff_q      <= woff_d;
            wdata_q     <= wdata_d;
            off_q       <= off_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_addr_q  <= fwd_addr_d;
            fwd_data_q  <= fwd_data_d;
            data_out_q  <= data_out_d;
            if (fill_done) begin
                valid_q[idx_q] <= 1'b1;
                dirty_q[idx_q] <= 1'b0;
            end
            if (dirty_set) begin
                dirty_q[idx_q] <= 1'b1;
            end
        end
    end

    // Tag array: written when a fill completes, read synchronously at accept
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_mem[idx_q] <= tag_q;
        end
        if (accept) begin
            tag_rd_q <= tag_mem[req_idx];
        end
    end

    dcache_data_ram #(
        .AW(RAM_AW)
    ) u_data_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    assign bus.data_out  = data_out_d;
    assign bus.miss      = miss_d;
    assign bus.mem_req   = (state_q == S_WB) || (state_q == S_FILL);
    assign bus.mem_we    = (state_q == S_WB);
    assign bus.mem_addr  = (state_q == S_WB)   ? {tag_rd_q, idx_q, off_q, 2'b00} :
                           (state_q == S_FILL) ? {tag_q,    idx_q, off_q, 2'b00} : 32'h0;
    assign bus.mem_wdata = (state_q == S_WB) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - directed self-checking bench for dcache_controller

module tb_dcache_controller;

    logic clk;
    logic rstn;
    int   checks;
    int   failures;

    dcache_controller_if bus ();

    dcache_controller dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.read_enable  = 1'b0;
        bus.write_enable = 1'b0;
    endtask

    // Present one request and advance to the cycle in which it resolves
    task automatic req(input logic we, input logic [31:0] a, input logic [31:0] d);
        bus.write_enable = we;
        bus.read_enable  = !we;
        bus.addr         = a;
        bus.data_in      = d;
        step();
    endtask

    // Check the outstanding backing-memory word, then ack it for one cycle
    task automatic serve(input string tag, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd);
        chk1({tag, ".req"}, bus.mem_req, 1'b1);
        chk1({tag, ".we"}, bus.mem_we, we);
        chk32({tag, ".addr"}, bus.mem_addr, a);
        if (we) begin
            chk32({tag, ".wdata"}, bus.mem_wdata, wd);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rd;
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rstn             = 1'b0;
        bus.addr         = 32'h0;
        bus.data_in      = 32'h0;
        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b0;
        bus.mem_ack      = 1'b0;
        bus.mem_rdata    = 32'h0;
        step();
        step();

        // Reset state
        chk1("rst.ready", bus.ready, 1'b0);
        chk1("rst.miss", bus.miss, 1'b0);
        chk32("rst.data_out", bus.data_out, 32'h0);
        chk1("rst.mem_req", bus.mem_req, 1'b0);
        chk1("rst.mem_we", bus.mem_we, 1'b0);
        chk32("rst.mem_addr", bus.mem_addr, 32'h0);
        chk32("rst.mem_wdata", bus.mem_wdata, 32'h0);
        rstn = 1'b1;
        step();
        chk1("idle.ready", bus.ready, 1'b1);

        // Cold read miss on 0x1004: clean fill of 0x1000..0x100C
        req(1'b0, 32'h0000_1004, 32'h0);
        chk1("cold.miss", bus.miss, 1'b1);
        chk1("cold.ready", bus.ready, 1'b0);
        idle();
        step();
        chk32("cold.stall.addr0", bus.mem_addr, 32'h0000_1000);
        bus.read_enable = 1'b1;
        bus.addr        = 32'h0000_5000;
        step();
        idle();
        chk1("cold.stall.req", bus.mem_req, 1'b1);
        chk32("cold.stall.addr1", bus.mem_addr, 32'h0000_1000);
        serve("cold.f0", 1'b0, 32'h0000_1000, 32'h0, 32'hA000_1000);
        serve("cold.f1", 1'b0, 32'h0000_1004, 32'h0, 32'hA000_1004);
        serve("cold.f2", 1'b0, 32'h0000_1008, 32'h0, 32'hA000_1008);
        serve("cold.f3", 1'b0, 32'h0000_100C, 32'h0, 32'hA000_100C);
        chk1("cold.done.miss", bus.miss, 1'b1);
        chk1("cold.done.mem_req", bus.mem_req, 1'b0);
        step();
        chk1("cold.fin.miss", bus.miss, 1'b0);
        chk1("cold.fin.ready", bus.ready, 1'b1);
        chk32("cold.fin.data", bus.data_out, 32'hA000_1004);
        step();
        chk32("cold.hold.data", bus.data_out, 32'hA000_1004);

        // Repeat read hits, then back-to-back hits at one per cycle
        req(1'b0, 32'h0000_1004, 32'h0);
        chk1("hit.miss", bus.miss, 1'b0);
        chk32("hit.data", bus.data_out, 32'hA000_1004);
        req(1'b0, 32'h0000_1000, 32'h0);
        chk1("b2b0.miss", bus.miss, 1'b0);
        chk32("b2b0.data", bus.data_out, 32'hA000_1000);
        req(1'b0, 32'h0000_1008, 32'h0);
        chk1("b2b1.miss", bus.miss, 1'b0);
        chk32("b2b1.data", bus.data_out, 32'hA000_1008);
        req(1'b0, 32'h0000_100C, 32'h0);
        chk1("b2b2.miss", bus.miss, 1'b0);
        chk32("b2b2.data", bus.data_out, 32'hA000_100C);
        idle();
        step();

        // Store hit followed immediately by a load of the same word
        req(1'b1, 32'h0000_1008, 32'hDEAD_BEEF);
        chk1("wr.miss", bus.miss, 1'b0);
        chk1("wr.ready", bus.ready, 1'b1);
        req(1'b0, 32'h0000_1008, 32'h0);
        chk1("fwd.miss", bus.miss, 1'b0);
        chk32("fwd.data", bus.data_out, 32'hDEAD_BEEF);
        idle();
        step();

        // Conflict read 0x2008 evicts dirty line 0x1000
        req(1'b0, 32'h0000_2008, 32'h0);
        chk1("evict1.miss", bus.miss, 1'b1);
        idle();
        step();
        serve("evict1.wb0", 1'b1, 32'h0000_1000, 32'hA000_1000, 32'h0);
        serve("evict1.wb1", 1'b1, 32'h0000_1004, 32'hA000_1004, 32'h0);
        serve("evict1.wb2", 1'b1, 32'h0000_1008, 32'hDEAD_BEEF, 32'h0);
        serve("evict1.wb3", 1'b1, 32'h0000_100C, 32'hA000_100C, 32'h0);
        serve("evict1.f0", 1'b0, 32'h0000_2000, 32'h0, 32'hA000_2000);
        serve("evict1.f1", 1'b0, 32'h0000_2004, 32'h0, 32'hA000_2004);
        serve("evict1.f2", 1'b0, 32'h0000_2008, 32'h0, 32'hA000_2008);
        serve("evict1.f3", 1'b0, 32'h0000_200C, 32'h0, 32'hA000_200C);
        chk1("evict1.done.miss", bus.miss, 1'b1);
        step();
        chk1("evict1.fin.miss", bus.miss, 1'b0);
        chk32("evict1.fin.data", bus.data_out, 32'hA000_2008);

        // Store miss to 0x3004 on a clean victim: fill then merge
        req(1'b1, 32'h0000_3004, 32'h1234_5678);
        chk1("wmiss.miss", bus.miss, 1'b1);
        idle();
        step();
        serve("wmiss.f0", 1'b0, 32'h0000_3000, 32'h0, 32'hA000_3000);
        serve("wmiss.f1", 1'b0, 32'h0000_3004, 32'h0, 32'hA000_3004);
        serve("wmiss.f2", 1'b0, 32'h0000_3008, 32'h0, 32'hA000_3008);
        serve("wmiss.f3", 1'b0, 32'h0000_300C, 32'h0, 32'hA000_300C);
        chk1("wmiss.done.miss", bus.miss, 1'b1);
        step();
        chk1("wmiss.fin.miss", bus.miss, 1'b0);
        chk1("wmiss.fin.ready", bus.ready, 1'b1);
        req(1'b0, 32'h0000_3004, 32'h0);
        chk1("wmiss.rd.miss", bus.miss, 1'b0);
        chk32("wmiss.rd.data", bus.data_out, 32'h1234_5678);
        idle();
        step();

        // Merged line must be dirty: reading 0x1004 writes it back
        req(1'b0, 32'h0000_1004, 32'h0);
        chk1("evict2.miss", bus.miss, 1'b1);
        idle();
        step();
        serve("evict2.wb0", 1'b1, 32'h0000_3000, 32'hA000_3000, 32'h0);
        serve("evict2.wb1", 1'b1, 32'h0000_3004, 32'h1234_5678, 32'h0);
        serve("evict2.wb2", 1'b1, 32'h0000_3008, 32'hA000_3008, 32'h0);
        serve("evict2.wb3", 1'b1, 32'h0000_300C, 32'hA000_300C, 32'h0);
        serve("evict2.f0", 1'b0, 32'h0000_1000, 32'h0, 32'hA000_1000);
        serve("evict2.f1", 1'b0, 32'h0000_1004, 32'h0, 32'hA000_1004);
        serve("evict2.f2", 1'b0, 32'h0000_1008, 32'h0, 32'hDEAD_BEEF);
        serve("evict2.f3", 1'b0, 32'h0000_100C, 32'h0, 32'hA000_100C);
        step();
        chk1("evict2.fin.miss", bus.miss, 1'b0);
        chk32("evict2.fin.data", bus.data_out, 32'hA000_1004);

        // Reset asserted on the second fill ack abandons the transfer
        req(1'b0, 32'h0000_2004, 32'h0);
        chk1("rstmid.miss", bus.miss, 1'b1);
        idle();
        step();
        serve("rstmid.f0", 1'b0, 32'h0000_2000, 32'h0, 32'hA000_2000);
        chk1("rstmid.f1.req", bus.mem_req, 1'b1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hA000_2004;
        rstn          = 1'b0;
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        chk1("rstmid.mem_req", bus.mem_req, 1'b0);
        chk1("rstmid.ready", bus.ready, 1'b0);
        chk1("rstmid.miss", bus.miss, 1'b0);
        chk32("rstmid.data_out", bus.data_out, 32'h0);
        rstn = 1'b1;
        step();
        chk1("rstmid.after.ready", bus.ready, 1'b1);

        // Every line invalid after reset: 0x1004 misses and fills without write-back
        req(1'b0, 32'h0000_1004, 32'h0);
        chk1("post.miss", bus.miss, 1'b1);
        idle();
        step();
        serve("post.f0", 1'b0, 32'h0000_1000, 32'h0, 32'hA000_1000);
        serve("post.f1", 1'b0, 32'h0000_1004, 32'h0, 32'hA000_1004);
        serve("post.f2", 1'b0, 32'h0000_1008, 32'h0, 32'hDEAD_BEEF);
        serve("post.f3", 1'b0, 32'h0000_100C, 32'h0, 32'hA000_100C);
        step();
        chk1("post.fin.miss", bus.miss, 1'b0);
        chk32("post.fin.data", bus.data_out, 32'hA000_1004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
